cpu_req_sequencer: RTL and testbench

- Parametrised, programmable CPU-side request generator for cache/memory bring-up. It replaces the fixed, hard-coded request list and free-running hit counter with a handshake-driven, self-checking sequencer.
- Holds a table of up to DEPTH requests (read/write, address, write data, expected read data). A start pulse replays them to the cache one at a time.
- Each read is optionally checked against its expected value. Every request has a timeout guard, and pass/fail status is reported.
- Sits between the bench/top and the Cache request port.

---
 rtl/cpu_req_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cpu_req_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_req_sequencer.sv
// Programmable CPU-side request sequencer: replays a table of read/write requests
// to the cache one at a time, checks read data, and guards every request with a timeout.
module cpu_req_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 32,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [IDX_W-1:0]  prog_idx,
    input  logic              prog_rw,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    input  logic [DATA_W-1:0] prog_expect,
    input  logic              prog_check,
    input  logic              start,
    input  logic [IDX_W:0]    num_req,
    output logic              req_valid,
    output logic              r_w_type,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic              hit,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  req_index,
    output logic [IDX_W:0]    mismatch_cnt,
    output logic [IDX_W-1:0]  first_bad_idx,
    output logic              timeout_err
);

    localparam int               TMR_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]   DEPTH_CNT = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    state_t state, state_next;

    logic              tbl_rw     [DEPTH];
    logic [ADDR_W-1:0] tbl_addr   [DEPTH];
    logic [DATA_W-1:0] tbl_wdata  [DEPTH];
    logic [DATA_W-1:0] tbl_expect [DEPTH];
    logic              tbl_check  [DEPTH];

    logic [IDX_W-1:0]  last_idx;
    logic              cur_check;
    logic [DATA_W-1:0] cur_expect;
    logic [TMR_W-1:0]  timer;

    logic [IDX_W:0]    num_clamped;
    logic              is_last;
    logic              time_up;
    logic              read_bad;

    // Table storage has no reset so a bring-up program survives rst.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            tbl_rw[prog_idx]     <= prog_rw;
            tbl_addr[prog_idx]   <= prog_addr;
            tbl_wdata[prog_idx]  <= prog_wdata;
            tbl_expect[prog_idx] <= prog_expect;
            tbl_check[prog_idx]  <= prog_check;
        end
    end

    assign num_clamped = (num_req > DEPTH_CNT) ? DEPTH_CNT : num_req;
    assign is_last     = (req_index == last_idx);
    assign time_up     = (timer == TMR_LAST);
    assign read_bad    = !r_w_type && cur_check && (read_data != cur_expect);
    assign busy        = (state == ISSUE) || (state == WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A hit in the final timer cycle takes priority over the timeout abort.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_req == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE:  state_next = WAIT;
            WAIT: begin
                if (hit) begin
                    state_next = is_last ? FINISH : ISSUE;
                end else if (time_up) begin
                    state_next = FINISH;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid     <= 1'b0;
            r_w_type      <= 1'b0;
            address       <= '0;
            write_data    <= '0;
            done          <= 1'b0;
            req_index     <= '0;
            mismatch_cnt  <= '0;
            first_bad_idx <= '0;
            timeout_err   <= 1'b0;
            last_idx      <= '0;
            cur_check     <= 1'b0;
            cur_expect    <= '0;
            timer         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        last_idx      <= IDX_W'(num_clamped - 1'b1);
                        done          <= 1'b0;
                        mismatch_cnt  <= '0;
                        first_bad_idx <= '0;
                        timeout_err   <= 1'b0;
                        req_index     <= '0;
                    end
                end
                ISSUE: begin
                    r_w_type   <= tbl_rw[req_index];
                    address    <= tbl_addr[req_index];
                    write_data <= tbl_wdata[req_index];
                    cur_check  <= tbl_check[req_index];
                    cur_expect <= tbl_expect[req_index];
                    req_valid  <= 1'b1;
                    timer      <= '0;
                end
                WAIT: begin
                    if (hit) begin
                        req_valid <= 1'b0;
                        if (read_bad) begin
                            if (mismatch_cnt == '0) begin
                                first_bad_idx <= req_index;
                            end
                            if (mismatch_cnt != {(IDX_W + 1){1'b1}}) begin
                                mismatch_cnt <= mismatch_cnt + 1'b1;
                            end
                        end
                        if (!is_last) begin
                            req_index <= req_index + 1'b1;
                        end
                    end else if (time_up) begin
                        timeout_err <= 1'b1;
                        req_valid   <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FINISH: done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_req_sequencer.sv
// Directed bench for cpu_req_sequencer: a vector table replay plus hand-written
// sequences for timeout, hit/timeout collision, ignored hits, mid-replay reset and clamping.
module tb_cpu_req_sequencer;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 32;
    localparam int IDX_W   = 5;
    localparam int TIMEOUT = 64;
    localparam int NVEC    = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              prog_we;
    logic [IDX_W-1:0]  prog_idx;
    logic              prog_rw;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_wdata;
    logic [DATA_W-1:0] prog_expect;
    logic              prog_check;
    logic              start;
    logic [IDX_W:0]    num_req;
    logic              req_valid;
    logic              r_w_type;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              hit;
    logic [DATA_W-1:0] read_data;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  req_index;
    logic [IDX_W:0]    mismatch_cnt;
    logic [IDX_W-1:0]  first_bad_idx;
    logic              timeout_err;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_data;
        logic              chk;
        logic [DATA_W-1:0] rdata;
        int                delay;
        logic [IDX_W:0]    exp_mis;
    } vec_t;

    vec_t vecs [NVEC];

    cpu_req_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_we      (prog_we),
        .prog_idx     (prog_idx),
        .prog_rw      (prog_rw),
        .prog_addr    (prog_addr),
        .prog_wdata   (prog_wdata),
        .prog_expect  (prog_expect),
        .prog_check   (prog_check),
        .start        (start),
        .num_req      (num_req),
        .req_valid    (req_valid),
        .r_w_type     (r_w_type),
        .address      (address),
        .write_data   (write_data),
        .hit          (hit),
        .read_data    (read_data),
        .busy         (busy),
        .done         (done),
        .req_index    (req_index),
        .mismatch_cnt (mismatch_cnt),
        .first_bad_idx(first_bad_idx),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic progEntry(input int idx, input logic rw, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_data,
                             input logic chk);
        prog_we     = 1'b1;
        prog_idx    = IDX_W'(idx);
        prog_rw     = rw;
        prog_addr   = addr;
        prog_wdata  = wdata;
        prog_expect = exp_data;
        prog_check  = chk;
        step();
        prog_we = 1'b0;
    endtask

    task automatic startReplay(input logic [IDX_W:0] n);
        start   = 1'b1;
        num_req = n;
        step();
        start   = 1'b0;
        num_req = '0;
    endtask

    task automatic waitReqValid(input string name);
        int guard = 0;
        while (!req_valid && guard < 10) begin
            step();
            guard++;
        end
        checkOutput(name, {31'b0, req_valid}, 32'd1);
    endtask

    task automatic respondHit(input logic [DATA_W-1:0] rdata);
        hit       = 1'b1;
        read_data = rdata;
        step();
        hit       = 1'b0;
        read_data = '0;
    endtask

    // One table-driven request/response exchange.
    task automatic applyStimulus(input int i);
        waitReqValid($sformatf("vec%0d_req_valid", i));
        checkOutput($sformatf("vec%0d_rw", i), {31'b0, r_w_type}, {31'b0, vecs[i].rw});
        checkOutput($sformatf("vec%0d_addr", i), {22'b0, address}, {22'b0, vecs[i].addr});
        checkOutput($sformatf("vec%0d_wdata", i), write_data, vecs[i].wdata);
        checkOutput($sformatf("vec%0d_index", i), {27'b0, req_index}, i);
        repeat (vecs[i].delay) step();
        checkOutput($sformatf("vec%0d_held_addr", i), {22'b0, address}, {22'b0, vecs[i].addr});
        respondHit(vecs[i].rdata);
        checkOutput($sformatf("vec%0d_drop", i), {31'b0, req_valid}, 32'd0);
        checkOutput($sformatf("vec%0d_mis", i), {26'b0, mismatch_cnt}, {26'b0, vecs[i].exp_mis});
    endtask

    initial begin
        vecs[0] = '{1'b0, 10'h014, 32'h0,        32'h0,        1'b1, 32'h0,        2, 6'd0};
        vecs[1] = '{1'b0, 10'h054, 32'h0,        32'h00001919, 1'b1, 32'h0,        2, 6'd1};
        vecs[2] = '{1'b1, 10'h06C, 32'h00114514, 32'h0,        1'b1, 32'hDEADBEEF, 2, 6'd1};
        vecs[3] = '{1'b0, 10'h100, 32'h0,        32'hCAFEF00D, 1'b0, 32'h0,        0, 6'd1};
        vecs[4] = '{1'b0, 10'h3FC, 32'h0,        32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 5, 6'd1};
        vecs[5] = '{1'b0, 10'h200, 32'h0,        32'h12345678, 1'b1, 32'h12345679, 1, 6'd2};

        rst = 1'b1; prog_we = 1'b0; prog_idx = '0; prog_rw = 1'b0; prog_addr = '0;
        prog_wdata = '0; prog_expect = '0; prog_check = 1'b0; start = 1'b0;
        num_req = '0; hit = 1'b0; read_data = '0;
        step();
        step();
        rst = 1'b0;
        checkOutput("rst_req_valid", {31'b0, req_valid}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_index", {27'b0, req_index}, 32'd0);
        checkOutput("rst_mis", {26'b0, mismatch_cnt}, 32'd0);
        checkOutput("rst_timeout", {31'b0, timeout_err}, 32'd0);

        $display("[TB] table replay");
        for (int i = 0; i < NVEC; i++) begin
            progEntry(i, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data, vecs[i].chk);
        end
        startReplay(6'(NVEC));
        checkOutput("start_busy", {31'b0, busy}, 32'd1);
        checkOutput("start_latency", {31'b0, req_valid}, 32'd0);
        step();
        checkOutput("issue_latency", {31'b0, req_valid}, 32'd1);
        for (int i = 0; i < NVEC; i++) applyStimulus(i);
        checkOutput("replay_done_early", {31'b0, done}, 32'd0);
        step();
        checkOutput("replay_done", {31'b0, done}, 32'd1);
        checkOutput("replay_busy", {31'b0, busy}, 32'd0);
        checkOutput("replay_index", {27'b0, req_index}, 32'd5);
        checkOutput("replay_first_bad", {27'b0, first_bad_idx}, 32'd1);
        checkOutput("replay_timeout", {31'b0, timeout_err}, 32'd0);

        $display("[TB] timeout after %0d wait cycles", TIMEOUT);
        startReplay(6'd2);
        step();
        checkOutput("to_req_valid", {31'b0, req_valid}, 32'd1);
        checkOutput("to_mis_cleared", {26'b0, mismatch_cnt}, 32'd0);
        repeat (TIMEOUT - 1) step();
        checkOutput("to_not_yet", {31'b0, timeout_err}, 32'd0);
        checkOutput("to_still_valid", {31'b0, req_valid}, 32'd1);
        step();
        checkOutput("to_err", {31'b0, timeout_err}, 32'd1);
        checkOutput("to_drop", {31'b0, req_valid}, 32'd0);
        step();
        checkOutput("to_done", {31'b0, done}, 32'd1);
        checkOutput("to_index", {27'b0, req_index}, 32'd0);

        $display("[TB] hit in the expiry cycle");
        startReplay(6'd1);
        step();
        repeat (TIMEOUT - 1) step();
        respondHit(32'h0);
        checkOutput("race_timeout", {31'b0, timeout_err}, 32'd0);
        step();
        checkOutput("race_done", {31'b0, done}, 32'd1);
        checkOutput("race_timeout_final", {31'b0, timeout_err}, 32'd0);
        checkOutput("race_mis", {26'b0, mismatch_cnt}, 32'd0);

        $display("[TB] hits while req_valid low, then reset in WAIT");
        hit = 1'b1;
        read_data = 32'hFFFFFFFF;
        repeat (3) step();
        checkOutput("idle_hit_index", {27'b0, req_index}, 32'd0);
        checkOutput("idle_hit_done", {31'b0, done}, 32'd1);
        hit = 1'b0;
        startReplay(6'd3);
        hit = 1'b1;
        step();
        hit = 1'b0;
        read_data = '0;
        checkOutput("issue_hit_index", {27'b0, req_index}, 32'd0);
        checkOutput("issue_hit_valid", {31'b0, req_valid}, 32'd1);
        checkOutput("issue_hit_mis", {26'b0, mismatch_cnt}, 32'd0);
        respondHit(32'h0);
        waitReqValid("rst_seq_req1");
        respondHit(32'h0);
        waitReqValid("rst_seq_req2");
        checkOutput("rst_seq_index", {27'b0, req_index}, 32'd2);
        checkOutput("rst_seq_mis", {26'b0, mismatch_cnt}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_valid", {31'b0, req_valid}, 32'd0);
        checkOutput("midrst_done", {31'b0, done}, 32'd0);
        checkOutput("midrst_mis", {26'b0, mismatch_cnt}, 32'd0);
        checkOutput("midrst_first_bad", {27'b0, first_bad_idx}, 32'd0);

        $display("[TB] zero-length replay");
        startReplay(6'd0);
        checkOutput("zero_valid0", {31'b0, req_valid}, 32'd0);
        checkOutput("zero_done_early", {31'b0, done}, 32'd0);
        step();
        checkOutput("zero_valid1", {31'b0, req_valid}, 32'd0);
        checkOutput("zero_done", {31'b0, done}, 32'd1);

        $display("[TB] num_req clamped to DEPTH");
        for (int i = 0; i < DEPTH; i++) begin
            progEntry(i, 1'b1, ADDR_W'(i * 4), DATA_W'(i), 32'h0, 1'b0);
        end
        startReplay(6'd40);
        for (int i = 0; i < DEPTH; i++) begin
            waitReqValid($sformatf("clamp%0d_valid", i));
            checkOutput($sformatf("clamp%0d_addr", i), {22'b0, address}, i * 4);
            respondHit(32'h0);
        end
        step();
        checkOutput("clamp_done", {31'b0, done}, 32'd1);
        checkOutput("clamp_valid", {31'b0, req_valid}, 32'd0);
        checkOutput("clamp_index", {27'b0, req_index}, 32'(DEPTH - 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
